asym_pack_fifo: RTL and testbench

Narrow-to-wide packing FIFO for the PairHMM AFU result path. It accepts 48-bit result words one at a time and packs RATIO of them into 384-bit lines. Lines are held in an internal line FIFO and drained over a valid/ready stream to the host write-back logic. It is the writer-narrow/reader-wide counterpart of the wide-write/narrow-read asymmetric RAM used on the input path, and uses the same lane ordering: narrow word i occupies bits [(i+1)*WIDTHIN-1 -: WIDTHIN].

---
 rtl/asym_pack_fifo_if.sv | 29 ++
 rtl/asym_pack_fifo.sv | 124 ++++++++++++
 tb/tb_asym_pack_fifo.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/asym_pack_fifo_if.sv
// Narrow-word input stream and wide-line output stream of asym_pack_fifo.
// The slave modport is the FIFO's view; the master modport is the producer/consumer view.
interface asym_pack_fifo_if #(
    parameter int WIDTHIN  = 48,
    parameter int WIDTHOUT = 384,
    parameter int DEPTH    = 16
);
    localparam int RATIO = WIDTHOUT / WIDTHIN;

    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTHIN-1:0]         in_data;
    logic                       in_last;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTHOUT-1:0]        out_data;
    logic [$clog2(RATIO):0]     out_count;
    logic [$clog2(DEPTH):0]     level;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, level
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, level
    );
endinterface

// File: rtl/asym_pack_fifo.sv
// Narrow-to-wide packing FIFO: packs RATIO narrow words into one line, queues
// lines in a DEPTH-1 entry circular buffer backed by a registered output stage.
module asym_pack_lane #(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!reset_n || clr) q <= '0;
        else if (we)         q <= d;
    end
endmodule

module asym_pack_fifo #(
    parameter int WIDTHIN  = 48,
    parameter int WIDTHOUT = 384,
    parameter int RATIO    = WIDTHOUT / WIDTHIN,
    parameter int DEPTH    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    asym_pack_fifo_if.slave  bus
);
    localparam int LW   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int CW   = $clog2(RATIO) + 1;
    localparam int MEMD = DEPTH - 1;
    localparam int PW   = (MEMD > 1) ? $clog2(MEMD) : 1;
    localparam int LVW  = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [CW-1:0]                  count;
        logic [RATIO-1:0][WIDTHIN-1:0]  data;
    } line_t;

    logic [LW-1:0]                  lane;
    logic [RATIO-1:0][WIDTHIN-1:0]  packQ;
    logic [RATIO-1:0][WIDTHIN-1:0]  lineData;
    logic [RATIO-1:0]               laneWe;
    logic                           accept;
    logic                           commit;
    line_t                          newLine;

    line_t                          mem [MEMD];
    line_t                          outReg;
    logic                           outValid;
    logic [PW-1:0]                  wrPtr;
    logic [PW-1:0]                  rdPtr;
    logic [LVW-1:0]                 memCnt;
    logic [LVW-1:0]                 levelCnt;
    logic                           pop;
    logic                           load;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(MEMD - 1)) ? '0 : p + PW'(1);
    endfunction

    assign accept = bus.in_valid & bus.in_ready;
    assign commit = accept & ((lane == LW'(RATIO - 1)) | bus.in_last);

    // The committed line merges the incoming word into its lane; lanes above
    // the current one are still zero because the pack register clears on commit.
    for (genvar i = 0; i < RATIO; i++) begin : g_lane
        assign laneWe[i]   = accept & ~commit & (lane == LW'(i));
        assign lineData[i] = (accept && lane == LW'(i)) ? bus.in_data : packQ[i];

        asym_pack_lane #(.W(WIDTHIN)) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (commit),
            .we      (laneWe[i]),
            .d       (bus.in_data),
            .q       (packQ[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n)    lane <= '0;
        else if (commit) lane <= '0;
        else if (accept) lane <= lane + LW'(1);
    end

    assign newLine.count = CW'(lane) + CW'(1);
    assign newLine.data  = lineData;

    // Commits always land in memory; the output stage refills from the head, so
    // the memory can never overflow while level < DEPTH admits new words.
    assign pop  = outValid & bus.out_ready;
    assign load = (memCnt != '0) & (~outValid | pop);

    always_ff @(posedge clk) begin
        if (commit) mem[wrPtr] <= newLine;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            memCnt   <= '0;
            outValid <= 1'b0;
            outReg   <= '0;
        end else begin
            if (commit) wrPtr <= nextPtr(wrPtr);
            if (load) begin
                rdPtr  <= nextPtr(rdPtr);
                outReg <= mem[rdPtr];
            end
            memCnt <= memCnt + LVW'(commit) - LVW'(load);
            if (load)     outValid <= 1'b1;
            else if (pop) outValid <= 1'b0;
        end
    end

    assign levelCnt      = memCnt + LVW'(outValid);
    assign bus.level     = levelCnt;
    assign bus.in_ready  = levelCnt < LVW'(DEPTH);
    assign bus.out_valid = outValid;
    assign bus.out_data  = outReg.data;
    assign bus.out_count = outReg.count;
endmodule

// File: tb/tb_asym_pack_fifo.sv
// Bench for asym_pack_fifo: a negedge monitor models packing and level, pushes
// expected lines to a scoreboard at commit and compares them at pop.
module tb_asym_pack_fifo;
    localparam int WIN   = 48;
    localparam int WOUT  = 384;
    localparam int RATIO = 8;
    localparam int DEPTH = 16;

    typedef struct {
        logic [3:0]      cnt;
        logic [WOUT-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    exp_t            sbq[$];
    logic [WOUT-1:0] mLine = '0;
    int              mLane = 0;
    int              mLevel = 0;

    asym_pack_fifo_if #(.WIDTHIN(WIN), .WIDTHOUT(WOUT), .DEPTH(DEPTH)) bus ();

    asym_pack_fifo #(.WIDTHIN(WIN), .WIDTHOUT(WOUT), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [399:0] got, input logic [399:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Handshakes are evaluated mid-low-phase; they take effect at the next rising edge.
    always @(negedge clk) begin : mon
        bit   acc, pp, cm;
        exp_t e;
        #2;
        if (!reset_n) begin
            sbq.delete();
            mLine  = '0;
            mLane  = 0;
            mLevel = 0;
        end else begin
            acc = bus.in_valid & bus.in_ready;
            pp  = bus.out_valid & bus.out_ready;
            cm  = 1'b0;
            chk("level", bus.level, mLevel);
            chk("in_ready", bus.in_ready, mLevel < DEPTH);
            if (pp) begin
                chk("sb_avail", sbq.size() > 0, 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("out_count", bus.out_count, e.cnt);
                    chk("out_data", bus.out_data, e.data);
                end
            end
            if (acc) begin
                mLine[mLane*WIN +: WIN] = bus.in_data;
                if (mLane == RATIO - 1 || bus.in_last) begin
                    e.cnt  = 4'(mLane + 1);
                    e.data = mLine;
                    sbq.push_back(e);
                    mLine = '0;
                    mLane = 0;
                    cm    = 1'b1;
                end else begin
                    mLane++;
                end
            end
            mLevel = mLevel + int'(cm) - int'(pp);
        end
    end

    task automatic pushWord(input logic [WIN-1:0] d, input logic last);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        #1;
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) chk("push_timeout", bus.in_ready, 1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((bus.level != 0 || sbq.size() != 0) && n < 500) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("drain_level", bus.level, 0);
        chk("drain_sb", sbq.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_count", bus.out_count, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_in_ready", bus.in_ready, 1);

        // Full line and commit-to-valid latency
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) pushWord(48'(i), 1'b0);
        idle();
        #1;
        chk("lat_edge_t", bus.out_valid, 0);
        @(negedge clk);
        #1;
        chk("lat_edge_t1", bus.out_valid, 1);
        chk("line1_count", bus.out_count, 8);
        chk("line1_lane0", bus.out_data[47:0], 48'd1);
        chk("line1_lane7", bus.out_data[383:336], 48'd8);
        waitDrain();

        // Partial flush, then next word starts a new line at lane 0
        pushWord(48'hA0A0_0000_000A, 1'b0);
        pushWord(48'hB0B0_0000_000B, 1'b0);
        pushWord(48'hC0C0_0000_000C, 1'b1);
        pushWord(48'hD0D0_0000_000D, 1'b0);
        pushWord(48'hE0E0_0000_000E, 1'b1);
        // Single-word flush
        pushWord(48'h1234_5678_9ABC, 1'b1);
        idle();
        waitDrain();

        // Fill to DEPTH lines with the consumer stalled
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH * RATIO; i++) pushWord(48'h1000 + 48'(i), 1'b0);
        idle();
        #1;
        chk("full_level", bus.level, DEPTH);
        chk("full_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 48'hDEAD_BEEF_0129;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("full_hold_level", bus.level, DEPTH);
        end
        idle();
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("ready_after_pop", bus.in_ready, 1);
        waitDrain();

        // Simultaneous commit and pop at level 5
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5 * RATIO; i++) pushWord(48'h2000 + 48'(i), 1'b0);
        idle();
        repeat (2) @(negedge clk);
        #1;
        chk("lvl5", bus.level, 5);
        for (int i = 0; i < RATIO - 1; i++) pushWord(48'h3000 + 48'(i), 1'b0);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = 48'h3000 + 48'(RATIO - 1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("cp_level", bus.level, 5);
        bus.out_ready = 1'b1;
        waitDrain();

        // Reset with 5 lanes packed and 3 lines stored
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3 * RATIO + 5; i++) pushWord(48'h4000 + 48'(i), 1'b0);
        idle();
        #1;
        chk("pre_rst_level", bus.level, 3);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out_data", bus.out_data, 0);
        chk("mid_rst_out_count", bus.out_count, 0);
        chk("mid_rst_level", bus.level, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < RATIO; i++) pushWord(48'h5000 + 48'(i), 1'b0);
        idle();
        repeat (2) @(negedge clk);
        #1;
        chk("fresh_lane0", bus.out_data[47:0], 48'h5000);
        chk("fresh_count", bus.out_count, 8);
        waitDrain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
